// File: rtl/l2_cache_if.sv
// L1-request and memory-side signal bundle for the L2 cache controller.
// master drives requests and memory returns; slave is the controller.
interface l2_cache_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) ();
  logic              req_L1;
  logic              we_L1;
  logic [ADDR_W-1:0] addr_L1;
  logic [DATA_W-1:0] wdata_L1;
  logic [DATA_W-1:0] rdata_L1;
  logic              stall;
  logic              req_MEM;
  logic              we_MEM;
  logic [ADDR_W-1:0] addr_MEM;
  logic [DATA_W-1:0] wdata_MEM;
  logic [DATA_W-1:0] rdata_MEM;
  logic              stb;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  modport master (
    output req_L1, we_L1, addr_L1, wdata_L1, rdata_MEM, stb,
    input  rdata_L1, stall, req_MEM, we_MEM, addr_MEM, wdata_MEM, hit_count, miss_count
  );

  modport slave (
    input  req_L1, we_L1, addr_L1, wdata_L1, rdata_MEM, stb,
    output rdata_L1, stall, req_MEM, we_MEM, addr_MEM, wdata_MEM, hit_count, miss_count
  );
endinterface

// File: rtl/l2_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L2 cache controller.
// Line fills are bursts of LINE_BEATS words; each memory beat is a level change on stb.
//
// state     | meaning
// IDLE      | waiting for an L1 request
// LOOKUP    | tag compare, hit data or memory request issued
// FILL      | collecting line beats from memory
// WRITE_MEM | write-through in flight, waiting for one beat
// RESP      | result presented to L1, new request may be accepted
module l2_cache_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_BEATS = 8,
  parameter int NUM_SETS   = 64,
  parameter int CNT_W      = 16
) (
  input logic       clk,
  input logic       rst,
  l2_cache_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_BEATS);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WRITE_MEM, RESP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_q;
  logic [DATA_W-1:0] wdata_q;
  logic [OFF_W-1:0]  beat_cnt;
  logic              stb_q;
  logic [NUM_SETS-1:0] valid;
  logic [TAG_W-1:0]  tag_mem  [NUM_SETS-1:0];
  logic [DATA_W-1:0] data_mem [NUM_SETS-1:0][LINE_BEATS-1:0];

  logic [OFF_W-1:0] off_q;
  logic [IDX_W-1:0] idx_q;
  logic [TAG_W-1:0] tag_q;
  logic             hit;
  logic             beat;
  logic             last_beat;

  assign off_q     = addr_q[OFF_W-1:0];
  assign idx_q     = addr_q[OFF_W +: IDX_W];
  assign tag_q     = addr_q[ADDR_W-1 -: TAG_W];
  assign hit       = valid[idx_q] && (tag_mem[idx_q] == tag_q);
  assign beat      = bus.stb ^ stb_q;
  assign last_beat = (beat_cnt == OFF_W'(LINE_BEATS - 1));

  always_ff @(posedge clk) begin
    stb_q <= bus.stb;
    if (rst) begin
      state          <= IDLE;
      valid          <= '0;
      bus.hit_count  <= '0;
      bus.miss_count <= '0;
      bus.stall      <= 1'b0;
      bus.req_MEM    <= 1'b0;
      bus.we_MEM     <= 1'b1;
      bus.addr_MEM   <= '0;
      bus.wdata_MEM  <= '0;
      bus.rdata_L1   <= '0;
      beat_cnt       <= '0;
      addr_q         <= '0;
      rd_q           <= 1'b1;
      wdata_q        <= '0;
    end else begin
      case (state)
        IDLE, RESP: begin
          bus.stall <= 1'b0;
          state     <= IDLE;
          if (bus.req_L1) begin
            addr_q    <= bus.addr_L1;
            rd_q      <= bus.we_L1;
            wdata_q   <= bus.wdata_L1;
            bus.stall <= 1'b1;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (!(&bus.hit_count)) bus.hit_count <= bus.hit_count + 1'b1;
          end else begin
            if (!(&bus.miss_count)) bus.miss_count <= bus.miss_count + 1'b1;
          end
          if (rd_q) begin
            if (hit) begin
              bus.rdata_L1 <= data_mem[idx_q][off_q];
              bus.stall    <= 1'b0;
              state        <= RESP;
            end else begin
              bus.req_MEM  <= 1'b1;
              bus.we_MEM   <= 1'b1;
              bus.addr_MEM <= {tag_q, idx_q, {OFF_W{1'b0}}};
              beat_cnt     <= '0;
              state        <= FILL;
            end
          end else begin
            if (hit) data_mem[idx_q][off_q] <= wdata_q;
            bus.req_MEM   <= 1'b1;
            bus.we_MEM    <= 1'b0;
            bus.addr_MEM  <= addr_q;
            bus.wdata_MEM <= wdata_q;
            state         <= WRITE_MEM;
          end
        end
        FILL: begin
          if (beat) begin
            data_mem[idx_q][beat_cnt] <= bus.rdata_MEM;
            beat_cnt                  <= beat_cnt + 1'b1;
            if (last_beat) begin
              tag_mem[idx_q] <= tag_q;
              valid[idx_q]   <= 1'b1;
              // The requested word is still in flight when it is the final beat.
              bus.rdata_L1   <= (off_q == beat_cnt) ? bus.rdata_MEM : data_mem[idx_q][off_q];
              bus.req_MEM    <= 1'b0;
              bus.we_MEM     <= 1'b1;
              bus.stall      <= 1'b0;
              state          <= RESP;
            end
          end
        end
        WRITE_MEM: begin
          if (beat) begin
            bus.req_MEM <= 1'b0;
            bus.we_MEM  <= 1'b1;
            bus.stall   <= 1'b0;
            state       <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
